pcm_sample_feeder: RTL
======================

# pcm_sample_feeder

- Buffers decoded stereo PCM samples from the MP3 decoder.
- Presents one attenuated sample per audio frame on the 32-bit word that drives the codec serializer's `dac_data_in`.
- Advances on the serializer's `load_done_tick`, which pulses once per 48 kHz frame.
- Handles prefill, underrun and overflow so the codec never shifts out stale or partial data.

## Interface

Parameters:
- `ADDR_W`, default 4: FIFO address width; depth = 2^ADDR_W = 16 samples.
- `PREFILL`, default 8: FIFO level required before playback (re)starts. Legal range 1..2^ADDR_W.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: system clock, shared with the codec serializer.
- `reset_n`  in  1: asynchronous, active-high reset. The name follows codebase convention; polarity is high-active.
- `wr_en`  in  1: decoder write strobe, one sample per cycle.
- `wr_data`  in  32: sample, {left[15:0], right[15:0]}, two's complement.
- `load_done_tick`  in  1: one-cycle pulse from the serializer when it latches `dac_data`.
- `vol_shift`  in  4: attenuation; each channel is arithmetically shifted right by 0..15.
- `mute`  in  1: forces the output sample to zero.
- `clr_status`  in  1: clears `underrun_cnt` and `overflow`.
- `dac_data`  out  32: sample for the serializer (drives `dac_data_in`).
- `full`  out  1: FIFO full.
- `empty`  out  1: FIFO empty.
- `level`  out  ADDR_W+1: FIFO occupancy, 0..2^ADDR_W.
- `playing`  out  1: high in PLAY state.
- `underrun_cnt`  out  16: saturating count of underruns.
- `overflow`  out  1: sticky flag, set when a write is dropped.

## Operation

- FIFO write:
  - `wr_en` && !`full` stores `wr_data` and increments `level`.
  - `wr_en` && `full` drops the word and sets `overflow`.
- State machine, states FILL and PLAY; reset state is FILL.
  - FILL: `dac_data` is held at 0 and no pops occur. Move to PLAY on the first cycle with `level >= PREFILL`.
  - PLAY, `load_done_tick` with FIFO non-empty:
    - pop the head;
    - `dac_data` <= {L>>>vol_shift, R>>>vol_shift}, or 0 if `mute`.
  - PLAY, `load_done_tick` with FIFO empty:
    - `dac_data` <= 0;
    - `underrun_cnt` increments, saturating at 16'hFFFF;
    - state returns to FILL.
  - PLAY without a tick: `dac_data` holds.
- Arithmetic:
  - Shifts are sign-preserving per 16-bit channel; there is no rounding.
  - `vol_shift` = 15 gives 0 or -1.
  - `vol_shift` and `mute` are sampled only at pop time.
- Simultaneous write and pop: both take effect and `level` is unchanged. This also applies when the FIFO is full, because the pop frees a slot in the same cycle, so the write is accepted and `overflow` is not set.
- `clr_status` takes priority over a same-cycle underrun or overflow event; the event is lost.
- Pointers wrap modulo 2^ADDR_W. `level` is a separate counter, not derived from the pointers.
- `load_done_tick` in FILL is ignored.

## Timing

- Reset values:
  - `dac_data` 0, `full` 0, `empty` 1, `level` 0, `playing` 0, `underrun_cnt` 0, `overflow` 0;
  - state FILL; pointers 0.
- Reset asserted mid-operation flushes the FIFO and returns every output to its reset value immediately (asynchronous).
- Write-to-status latency: `level`, `full` and `empty` update on the clock edge that accepts the write.
- FILL to PLAY: `playing` rises on the edge after `level` first reaches PREFILL.
- Pop latency: `dac_data` changes on the edge following the `load_done_tick` cycle. It then stays stable for the whole frame, which is at least 2^LR·(serializer divide) cycles, so the next serializer load sees a settled word.
- One-frame pipeline: the sample popped at tick N is the one loaded by the serializer at tick N+1.
- The first frame after entering PLAY outputs 0.

## Structure

- Shared package `pcm_pkg`:
  - state enum {FILL, PLAY};
  - `SAMPLE_W` = 32 and `CH_W` = 16;
  - per-channel shift function `atten_ch(sample, shift)`.
- Sub-module `pcm_fifo`: synchronous single-clock FIFO with parameter `ADDR_W`.
  - Inputs: `wr_en`, `wr_data`, `rd_en`.
  - Outputs: `rd_data` (first-word-fall-through), `full`, `empty`, `level`.
- The top level holds the FSM, attenuation, output register and status logic.

## Test plan

- Prefill: write 7 samples, then pulse `load_done_tick` 3 times. Required: `playing` = 0 and `dac_data` = 0 throughout. Then write the 8th sample: `playing` = 1 one edge later and `level` = 8.
- Ordering and attenuation: preload {16'h4000, 16'hC000} ×8, `vol_shift` = 2. Each tick gives `dac_data` = {16'h1000, 16'hF000} one edge later and `level` decrements by 1. With `mute` = 1, the next pop gives 0.
- Underrun: in PLAY, drain all 8 samples with ticks, then one more tick. Required: `dac_data` = 0, `underrun_cnt` = 1, `playing` = 0. Ticks in FILL leave the count unchanged.
- Overflow and boundary: fill 16 samples, then:
  - write a 17th: `overflow` = 1 and `level` = 16;
  - write during a tick in the same cycle: `level` stays 16 and `overflow` is not re-triggered by that write;
  - `clr_status`: `overflow` = 0.
- Reset mid-play: with `level` = 10 and `dac_data` nonzero, assert `reset_n` between edges. Required immediately: `level` = 0, `empty` = 1, `dac_data` = 0, `playing` = 0.
- Saturation: force `underrun_cnt` to 16'hFFFE, cause 3 underruns. Required: it ends at 16'hFFFF.

Source files
------------

// File: rtl/pcm_pkg.sv
// -----------------------------------------------------------------------------
// pcm_pkg
// Shared definitions for the PCM sample feeder:
//   - state_t     : feeder state machine encoding (FILL, PLAY)
//   - SAMPLE_W    : width of one stereo sample word {left, right}
//   - CH_W        : width of one channel
//   - atten_ch    : sign-preserving right shift of one channel
//   - atten_sample: atten_ch applied independently to both channels
// -----------------------------------------------------------------------------
package pcm_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int SAMPLE_W = 32;
  localparam int CH_W     = 16;

  // Arithmetic shift keeps the sign bit, so negative values floor toward
  // minus infinity; a shift of 15 leaves only 0 or -1.
  function automatic logic [CH_W-1:0] atten_ch(input logic [CH_W-1:0] sample,
                                               input logic [3:0]      shift);
    logic signed [CH_W-1:0] shifted;
    shifted = $signed(sample) >>> shift;
    return shifted;
  endfunction

  // Left channel sits in the upper half of the word, right in the lower half.
  function automatic logic [SAMPLE_W-1:0] atten_sample(input logic [SAMPLE_W-1:0] sample,
                                                       input logic [3:0]          shift);
    return {atten_ch(sample[SAMPLE_W-1:CH_W], shift),
            atten_ch(sample[CH_W-1:0], shift)};
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// -----------------------------------------------------------------------------
// pcm_fifo
// Single-clock sample FIFO, depth 2^ADDR_W, first-word-fall-through read.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (flushes the FIFO)
//   wr_en      : write request; accepted when not full, or when full but a
//                read happens in the same cycle
//   wr_data    : sample to store
//   rd_en      : pop the head (ignored when empty)
//   rd_data    : current head of the FIFO (valid while !empty)
//   full/empty : registered status
//   level      : registered occupancy 0..2^ADDR_W, kept as its own counter
// -----------------------------------------------------------------------------
module pcm_fifo
  import pcm_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                full,
  output logic                empty,
  output logic [ADDR_W:0]     level
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W-1:0]   rd_ptr_r;
  logic [ADDR_W:0]     level_r;
  logic                full_r;
  logic                empty_r;

  logic                do_rd_s;
  logic                do_wr_s;
  logic [ADDR_W:0]     level_nxt_s;

  // Accept/pop qualification and next occupancy; a same-cycle pop frees the
  // slot that a write into a full FIFO needs.
  always_comb begin
    do_rd_s     = rd_en && !empty_r;
    do_wr_s     = wr_en && (!full_r || do_rd_s);
    level_nxt_s = level_r;
    if (do_wr_s && !do_rd_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (do_rd_s && !do_wr_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LVL_FULL);
      empty_r <= (level_nxt_s == '0);
    end
  end

  assign rd_data = mem[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign level   = level_r;

endmodule

// File: rtl/pcm_sample_feeder.sv
// -----------------------------------------------------------------------------
// pcm_sample_feeder
// Buffers decoded stereo PCM samples and hands one attenuated sample per
// audio frame to the codec serializer.
// Ports:
//   clk            : system clock shared with the serializer
//   reset_n        : asynchronous reset, ACTIVE HIGH despite the name
//   wr_en, wr_data : decoder write strobe and {left, right} sample
//   load_done_tick : serializer has latched dac_data; advance one frame
//   vol_shift      : per-channel arithmetic right shift 0..15
//   mute           : output zero instead of the popped sample
//   clr_status     : clear underrun_cnt and overflow (wins over new events)
//   dac_data       : registered sample for the serializer
//   full, empty    : FIFO status
//   level          : FIFO occupancy
//   playing        : high while in PLAY
//   underrun_cnt   : saturating underrun counter
//   overflow       : sticky dropped-write flag
// -----------------------------------------------------------------------------
module pcm_sample_feeder
  import pcm_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int PREFILL = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                load_done_tick,
  input  logic [3:0]          vol_shift,
  input  logic                mute,
  input  logic                clr_status,
  output logic [SAMPLE_W-1:0] dac_data,
  output logic                full,
  output logic                empty,
  output logic [ADDR_W:0]     level,
  output logic                playing,
  output logic [15:0]         underrun_cnt,
  output logic                overflow
);

  localparam logic [ADDR_W:0] PREFILL_L = (ADDR_W + 1)'(PREFILL);

  state_t              state_r;
  logic [SAMPLE_W-1:0] dac_data_r;
  logic                playing_r;
  logic [15:0]         underrun_cnt_r;
  logic                overflow_r;

  logic                pop_s;
  logic                underrun_s;
  logic                drop_s;
  logic [SAMPLE_W-1:0] head_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [ADDR_W:0]     fifo_level_s;

  pcm_fifo #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level_s)
  );

  // Frame events: a tick in PLAY either pops the head or is an underrun;
  // a write into a full FIFO is dropped only when no pop frees a slot.
  always_comb begin
    pop_s      = 1'b0;
    underrun_s = 1'b0;
    if (state_r == PLAY && load_done_tick) begin
      pop_s      = !fifo_empty_s;
      underrun_s = fifo_empty_s;
    end else begin
      pop_s      = 1'b0;
      underrun_s = 1'b0;
    end
    drop_s = wr_en && fifo_full_s && !pop_s;
  end

  // Feeder state machine with registered output sample and status.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_r        <= FILL;
      dac_data_r     <= '0;
      playing_r      <= 1'b0;
      underrun_cnt_r <= 16'h0000;
      overflow_r     <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          dac_data_r <= '0;
          if (fifo_level_s >= PREFILL_L) begin
            state_r   <= PLAY;
            playing_r <= 1'b1;
          end
        end
        PLAY: begin
          if (pop_s) begin
            dac_data_r <= mute ? '0 : atten_sample(head_s, vol_shift);
          end else if (underrun_s) begin
            dac_data_r <= '0;
            state_r    <= FILL;
            playing_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= FILL;
          playing_r  <= 1'b0;
          dac_data_r <= '0;
        end
      endcase

      if (clr_status) begin
        underrun_cnt_r <= 16'h0000;
        overflow_r     <= 1'b0;
      end else begin
        if (underrun_s && underrun_cnt_r != 16'hFFFF) begin
          underrun_cnt_r <= underrun_cnt_r + 16'h0001;
        end
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  assign dac_data     = dac_data_r;
  assign playing      = playing_r;
  assign underrun_cnt = underrun_cnt_r;
  assign overflow     = overflow_r;
  assign full         = fifo_full_s;
  assign empty        = fifo_empty_s;
  assign level        = fifo_level_s;

endmodule
